dsi_line_packetizer: RTL and testbench

//  Consumes the packed 32-bit pixel byte stream (frame-level sop/eop) produced by the video-to-byte

---
 rtl/dsi_line_packetizer.sv | 189 ++++++++++++++++++
 tb/tb_dsi_line_packetizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_line_packetizer.sv
// Splits a frame-level 32-bit pixel byte stream into DSI packets: one VSS short packet per frame,
// then per line a long packet (header, payload words, CRC-16 footer), one Avalon-ST packet each.
module dsi_line_packetizer #(
   parameter int unsigned LINE_BYTES = 2400,
   parameter int unsigned H_LINES    = 480,
   parameter logic [5:0]  DATA_TYPE  = 6'h3E,
   parameter logic [1:0]  VC         = 2'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   input  logic        in_sop_i,
   input  logic        in_eop_i,
   output logic        in_ready_o,
   output logic [31:0] out_data_o,
   output logic [3:0]  out_keep_o,
   output logic        out_valid_o,
   output logic        out_sop_o,
   output logic        out_eop_o,
   input  logic        out_ready_i,
   output logic        err_short_o,
   output logic        err_long_o
);

   localparam int unsigned Words = LINE_BYTES / 4;
   localparam int unsigned WordW = $clog2(Words + 1);
   localparam logic [WordW-1:0] LastWord = WordW'(Words - 1);
   localparam logic [11:0] LastLine = 12'(H_LINES - 1);
   localparam logic [23:0] VssHdr  = {16'h0000, VC, 6'h01};
   localparam logic [23:0] LongHdr = {16'(LINE_BYTES), VC, DATA_TYPE};

   typedef enum logic [2:0] {StIdle, StVss, StHdr, StPayload, StPad, StCrc, StDrop} state_e;

   // DSI header ECC: each parity bit is the XOR of the header bits selected by its mask.
   function automatic logic [7:0] ecc_f(input logic [23:0] d);
      return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
              ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
   endfunction

   // Reflected CRC-16 (0x8408), bits consumed LSB first, byte0 first.
   function automatic logic [15:0] crc_f(input logic [15:0] crc, input logic [31:0] w);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 32; i++) begin
         if (c[0] ^ w[i]) c = (c >> 1) ^ 16'h8408;
         else             c = c >> 1;
      end
      return c;
   endfunction

   state_e           state_q, state_d;
   logic [WordW-1:0] word_q, word_d;
   logic [11:0]      line_q, line_d;
   logic [15:0]      crc_q, crc_d;
   logic             ended_q, ended_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [3:0]       out_keep_q, out_keep_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sop_q, out_sop_d;
   logic             out_eop_q, out_eop_d;
   logic             err_short_q, err_short_d;
   logic             err_long_q, err_long_d;
   logic             ld, in_ready, last_word, last_line;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      line_d      = line_q;
      crc_d       = crc_q;
      ended_d     = ended_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      in_ready    = 1'b0;
      ld          = !out_valid_q || out_ready_i;
      last_word   = (word_q == LastWord);
      last_line   = (line_q == LastLine);

      // The output slot empties whenever it may load; states below refill it.
      if (ld) begin
         out_valid_d = 1'b0;
         out_sop_d   = 1'b0;
         out_eop_d   = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            in_ready = in_valid_i && !in_sop_i;
            if (in_valid_i && in_sop_i) state_d = StVss;
         end
         StVss: if (ld) begin
            {out_data_d, out_keep_d, out_valid_d, out_sop_d, out_eop_d} =
               {ecc_f(VssHdr), VssHdr, 4'hF, 3'b111};
            line_d  = '0;
            ended_d = 1'b0;
            state_d = StHdr;
         end
         StHdr: if (ld) begin
            {out_data_d, out_keep_d, out_valid_d, out_sop_d, out_eop_d} =
               {ecc_f(LongHdr), LongHdr, 4'hF, 3'b110};
            crc_d   = 16'hFFFF;
            word_d  = '0;
            state_d = ended_q ? StPad : StPayload;
         end
         StPayload: begin
            in_ready = ld;
            if (ld && in_valid_i) begin
               {out_data_d, out_keep_d, out_valid_d} = {in_data_i, 4'hF, 1'b1};
               crc_d  = crc_f(crc_q, in_data_i);
               word_d = word_q + 1'b1;
               if (in_eop_i) begin
                  ended_d     = 1'b1;
                  err_short_d = !(last_word && last_line);
               end
               if (last_word)     state_d = StCrc;
               else if (in_eop_i) state_d = StPad;
            end
         end
         StPad: if (ld) begin
            {out_data_d, out_keep_d, out_valid_d} = {32'h0, 4'hF, 1'b1};
            crc_d  = crc_f(crc_q, 32'h0);
            word_d = word_q + 1'b1;
            if (last_word) state_d = StCrc;
         end
         StCrc: if (ld) begin
            {out_data_d, out_keep_d, out_valid_d, out_eop_d} = {16'h0, crc_q, 4'h3, 2'b11};
            if (!last_line) begin
               line_d  = line_q + 1'b1;
               state_d = StHdr;
            end else if (ended_q) begin
               state_d = StIdle;
            end else begin
               err_long_d = 1'b1;
               state_d    = StDrop;
            end
         end
         StDrop: begin
            in_ready = ld;
            if (ld && in_valid_i && in_eop_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         word_q      <= '0;
         line_q      <= '0;
         crc_q       <= 16'hFFFF;
         ended_q     <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         line_q      <= line_d;
         crc_q       <= crc_d;
         ended_q     <= ended_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_data_o  = out_data_q;
   assign out_keep_o  = out_keep_q;
   assign out_valid_o = out_valid_q;
   assign out_sop_o   = out_sop_q;
   assign out_eop_o   = out_eop_q;
   assign err_short_o = err_short_q;
   assign err_long_o  = err_long_q;

endmodule

// File: tb/tb_dsi_line_packetizer.sv
// Bench for dsi_line_packetizer: random frames with random backpressure compared against a
// packet-level reference model, plus hand sequences for idle drop and mid-packet reset.
module tb_dsi_line_packetizer;

   localparam int unsigned LB = 12;
   localparam int unsigned HL = 2;
   localparam int unsigned W  = LB / 4;

   // ECC syndrome contributed by each header bit D0..D23.
   localparam logic [5:0] Syn [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
      6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   typedef struct {
      int nwords;
      int pct;
      int exp_short;
      int exp_long;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid, out_sop, out_eop;
   logic        out_ready = 1'b1;
   logic        err_short, err_long;

   int checks = 0, failures = 0;
   int short_cnt = 0, long_cnt = 0, stall_viol = 0, stall_pct = 0;
   logic [37:0] got [$];
   logic [37:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [37:0] prev_word = '0;

   dsi_line_packetizer #(.LINE_BYTES(LB), .H_LINES(HL), .DATA_TYPE(6'h3E), .VC(2'd0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_sop_i   (in_sop),
      .in_eop_i   (in_eop),
      .in_ready_o (in_ready),
      .out_data_o (out_data),
      .out_keep_o (out_keep),
      .out_valid_o(out_valid),
      .out_sop_o  (out_sop),
      .out_eop_o  (out_eop),
      .out_ready_i(out_ready),
      .err_short_o(err_short),
      .err_long_o (err_long)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
   end

   // Monitor: collect accepted words, count error pulses, watch stalled words stay put.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!out_valid || {out_data, out_keep, out_sop, out_eop} != prev_word))
            stall_viol++;
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_data, out_keep, out_sop, out_eop};
         if (out_valid && out_ready) got.push_back({out_data, out_keep, out_sop, out_eop});
         if (err_short) short_cnt++;
         if (err_long) long_cnt++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [7:0] m_ecc(input logic [23:0] d);
      logic [5:0] e = '0;
      for (int i = 0; i < 24; i++) if (d[i]) e ^= Syn[i];
      return {2'b00, e};
   endfunction

   function automatic logic [15:0] m_crc(input logic [15:0] crc, input logic [31:0] w);
      logic [15:0] c = crc;
      for (int b = 0; b < 4; b++) begin
         c ^= {8'h00, w[8*b +: 8]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c;
   endfunction

   // Expected packet stream for a frame of the given words.
   task automatic build_model(input logic [31:0] words [$]);
      logic [23:0] vss, hdr;
      logic [15:0] crc;
      logic [31:0] w;
      int          idx;
      exp_q.delete();
      vss = {16'h0000, 2'b00, 6'h01};
      hdr = {16'(LB), 2'b00, 6'h3E};
      exp_q.push_back({m_ecc(vss), vss, 4'hF, 1'b1, 1'b1});
      for (int l = 0; l < int'(HL); l++) begin
         exp_q.push_back({m_ecc(hdr), hdr, 4'hF, 1'b1, 1'b0});
         crc = 16'hFFFF;
         for (int k = 0; k < int'(W); k++) begin
            idx = l * int'(W) + k;
            w   = (idx < words.size()) ? words[idx] : 32'h0;
            exp_q.push_back({w, 4'hF, 1'b0, 1'b0});
            crc = m_crc(crc, w);
         end
         exp_q.push_back({16'h0000, crc, 4'h3, 1'b0, 1'b1});
      end
   endtask

   task automatic send_word(input logic [31:0] d, input bit s, input bit e, output bit ok);
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic run_frame(input int n, input int pct, input int es, input int el,
                            input string tag);
      logic [31:0] words [$];
      int          base, sbase, lbase;
      bit          ok;
      stall_pct = pct;
      base  = got.size();
      sbase = short_cnt;
      lbase = long_cnt;
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_model(words);
      ok = 1'b1;
      for (int i = 0; i < n && ok; i++) send_word(words[i], i == 0, i == n - 1, ok);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (got.size() - base >= exp_q.size() && !out_valid) break;
      end
      repeat (3) @(negedge clk);
      check({tag, "_len"}, 64'(got.size() - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (base + k < got.size())
            check($sformatf("%s_w%0d", tag, k), 64'(got[base + k]), 64'(exp_q[k]));
      check({tag, "_err_short"}, 64'(short_cnt - sbase), 64'(es));
      check({tag, "_err_long"}, 64'(long_cnt - lbase), 64'(el));
   endtask

   initial begin
      vec_t vecs [8];
      int   base, nacc;
      bit   ok;
      vecs[0] = '{6, 0, 0, 0};
      vecs[1] = '{6, 50, 0, 0};
      vecs[2] = '{4, 0, 1, 0};
      vecs[3] = '{9, 0, 0, 1};
      vecs[4] = '{1, 50, 1, 0};
      vecs[5] = '{3, 40, 1, 0};
      vecs[6] = '{9, 50, 0, 1};
      vecs[7] = '{6, 70, 0, 0};

      repeat (3) @(negedge clk);
      check("reset_outs", 64'({out_valid, out_sop, out_eop, out_keep, out_data, err_short,
                               err_long, in_ready}), 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Words without sop while idle are swallowed silently.
      base = got.size();
      nacc = 0;
      for (int i = 0; i < 3; i++) begin
         send_word($urandom, 1'b0, i == 2, ok);
         if (ok) nacc++;
      end
      in_valid = 1'b0;
      in_eop   = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_drop_acc", 64'(nacc), 64'd3);
      check("idle_drop_out", 64'(got.size() - base), 64'd0);
      check("idle_drop_err", 64'({short_cnt, long_cnt}), 64'd0);

      for (int i = 0; i < 8; i++) begin
         base = got.size();
         run_frame(vecs[i].nwords, vecs[i].pct, vecs[i].exp_short, vecs[i].exp_long,
                   $sformatf("vec%0d", i));
         if (i == 0 && got.size() >= base + 2) begin
            check("vss_word", 64'(got[base]), 64'({32'h07000001, 4'hF, 2'b11}));
            check("hdr_word", 64'(got[base + 1]), 64'({32'h08000C3E, 4'hF, 2'b10}));
         end
      end

      // Reset lands in the middle of line 0 payload.
      stall_pct = 0;
      send_word($urandom, 1'b1, 1'b0, ok);
      send_word($urandom, 1'b0, 1'b0, ok);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      @(negedge clk);
      check("pre_rst_busy", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", 64'({out_valid, out_sop, out_eop, out_keep, out_data, err_short,
                                 err_long, in_ready}), 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(6, 30, 0, 0, "post_rst");

      check("stall_hold", 64'(stall_viol), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
